// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32x32 register file: ALU (A) vs load unit (B).
// Fixed A priority with a starvation counter, one registered output stage.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   a_valid/a_ready/a_addr/a_data   ALU writeback requester
//   b_valid/b_ready/b_addr/b_data   load/multi-cycle requester
//   rf_wr/rf_sel/rf_data     registered register-file write port
//   chk_addr/chk_hit/chk_data  in-flight write lookup
// Build option: define RF_ARB_FWD_EN to build the in-flight lookup
// comparator; otherwise chk_hit/chk_data are tied to 0.
module regfile_wr_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        rf_wr,
    output logic [4:0]  rf_sel,
    output logic [31:0] rf_data,
    input  logic [4:0]  chk_addr,
    output logic        chk_hit,
    output logic [31:0] chk_data
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt;
    logic [3:0]  starve_nxt;
    logic        force_b;
    logic        grant_a;
    logic        grant_b;
    logic        granted;
    logic [4:0]  gnt_addr;
    logic [31:0] gnt_data;

    always_comb begin
        force_b  = b_valid && (starve_cnt == SMAX);
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        // No grants while reset is held, even with requests pending.
        if (rst) begin
            if (force_b)
                grant_b = 1'b1;
            else if (a_valid)
                grant_a = 1'b1;
            else if (b_valid)
                grant_b = 1'b1;
        end
        granted  = grant_a || grant_b;
        gnt_addr = grant_b ? b_addr : a_addr;
        gnt_data = grant_b ? b_data : a_data;

        starve_nxt = starve_cnt;
        if (!b_valid || grant_b)
            starve_nxt = 4'd0;
        else if (grant_a && (starve_cnt != SMAX))
            starve_nxt = starve_cnt + 4'd1;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
            rf_wr      <= 1'b0;
            rf_sel     <= 5'd0;
            rf_data    <= 32'd0;
        end else begin
            starve_cnt <= starve_nxt;
            // $0 writes are consumed but never reach the register file.
            rf_wr      <= granted && (gnt_addr != 5'd0);
            if (granted) begin
                rf_sel  <= gnt_addr;
                rf_data <= gnt_data;
            end
        end
    end

`ifdef RF_ARB_FWD_EN
    always_comb begin
        chk_hit  = rf_wr && (rf_sel == chk_addr);
        chk_data = chk_hit ? rf_data : 32'd0;
    end
`else
    logic unused_chk;
    assign unused_chk = ^chk_addr;
    assign chk_hit    = 1'b0;
    assign chk_data   = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: scoreboard of expected output-stage
// contents, filled from a reference grant model as stimulus is applied.
module tb_regfile_wr_arbiter;

    localparam int unsigned SM = 3;

    typedef struct packed {
        logic        wr;
        logic [4:0]  sel;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        rf_wr;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic [4:0]  chk_addr;
    logic        chk_hit;
    logic [31:0] chk_data;

    int passed = 0;
    int total  = 0;

    sb_t         sbq[$];
    logic [3:0]  mcnt;
    logic [4:0]  last_sel;
    logic [31:0] last_data;
    logic        obs_ar, obs_br, exp_ar, exp_br;

    regfile_wr_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_addr(b_addr), .b_data(b_data),
        .rf_wr(rf_wr), .rf_sel(rf_sel), .rf_data(rf_data),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .chk_data(chk_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mcnt      = 4'd0;
        last_sel  = 5'd0;
        last_data = 32'd0;
        sbq.delete();
    endtask

    // Called at posedge+1 with inputs set; samples ready mid-cycle,
    // runs the reference model across the edge, queues the expected
    // output-stage contents and returns at posedge+1.
    task automatic drive_cycle();
        logic frc, ga, gb;
        sb_t  e;
        #3;
        obs_ar = a_ready;
        obs_br = b_ready;
        frc = b_valid && (mcnt == 4'(SM));
        ga  = a_valid && !frc;
        gb  = frc || (!a_valid && b_valid);
        exp_ar = ga;
        exp_br = gb;
        @(posedge clk);
        if (!b_valid || gb)
            mcnt = 4'd0;
        else if (ga && mcnt != 4'(SM))
            mcnt = mcnt + 4'd1;
        e.wr = 1'b0;
        if (ga) begin
            e.wr = (a_addr != 5'd0);
            last_sel = a_addr;
            last_data = a_data;
        end else if (gb) begin
            e.wr = (b_addr != 5'd0);
            last_sel = b_addr;
            last_data = b_data;
        end
        e.sel  = last_sel;
        e.data = last_data;
        sbq.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd1; b_addr = 5'd2;
        a_data = 32'h1; b_data = 32'h2;
        chk_addr = 5'd0;
        repeat (2) @(posedge clk);
        #3;
        total++;
        if ({a_ready, b_ready} !== 2'b00)
            $display("FAIL reset_ready: got %b required 00", {a_ready, b_ready});
        else passed++;
        total++;
        if ({rf_wr, rf_sel, rf_data} !== 38'd0)
            $display("FAIL reset_rf: got wr=%b sel=%0d data=%h required 0/0/0",
                     rf_wr, rf_sel, rf_data);
        else passed++;
        total++;
        if ({chk_hit, chk_data} !== 33'd0)
            $display("FAIL reset_chk: got %b/%h required 0/0", chk_hit, chk_data);
        else passed++;
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_single_a();
        sb_t e;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        drive_cycle();
        total++;
        if (obs_ar !== 1'b1 || obs_ar !== exp_ar)
            $display("FAIL single_a_ready: got %b required 1", obs_ar);
        else passed++;
        e = sbq.pop_front();
        total++;
        if ({rf_wr, rf_sel, rf_data} !== {1'b1, 5'd5, 32'hDEADBEEF} ||
            {rf_wr, rf_sel, rf_data} !== e)
            $display("FAIL single_a_out: got %b/%0d/%h required 1/5/deadbeef",
                     rf_wr, rf_sel, rf_data);
        else passed++;
        a_valid = 1'b0;
        drive_cycle();
        e = sbq.pop_front();
        total++;
        if ({rf_wr, rf_sel, rf_data} !== e || rf_wr !== 1'b0)
            $display("FAIL single_a_idle: got %b/%0d/%h required %b/%0d/%h",
                     rf_wr, rf_sel, rf_data, e.wr, e.sel, e.data);
        else passed++;
    endtask

    task automatic test_starvation();
        sb_t e;
        logic [7:0] pat = 8'b1000_1000;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_addr = 5'(10 + i); a_data = 32'hA000_0000 + 32'(i);
            b_addr = 5'(20 + i); b_data = 32'hB000_0000 + 32'(i);
            drive_cycle();
            total++;
            if ({obs_ar, obs_br} !== {!pat[i], pat[i]} ||
                {obs_ar, obs_br} !== {exp_ar, exp_br})
                $display("FAIL starve_grant[%0d]: got a=%b b=%b required a=%b b=%b",
                         i, obs_ar, obs_br, !pat[i], pat[i]);
            else passed++;
            e = sbq.pop_front();
            total++;
            if ({rf_wr, rf_sel, rf_data} !== e)
                $display("FAIL starve_out[%0d]: got %b/%0d/%h required %b/%0d/%h",
                         i, rf_wr, rf_sel, rf_data, e.wr, e.sel, e.data);
            else passed++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        drive_cycle();
        void'(sbq.pop_front());
    endtask

    task automatic test_zero_drop();
        sb_t e;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h12345678;
        drive_cycle();
        total++;
        if (obs_br !== 1'b1 || obs_ar !== 1'b0)
            $display("FAIL zero_ready: got a=%b b=%b required a=0 b=1", obs_ar, obs_br);
        else passed++;
        e = sbq.pop_front();
        total++;
        if (rf_wr !== 1'b0 || {rf_wr, rf_sel, rf_data} !== e)
            $display("FAIL zero_out: got %b/%0d/%h required %b/%0d/%h",
                     rf_wr, rf_sel, rf_data, e.wr, e.sel, e.data);
        else passed++;
        b_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        sb_t e;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = 5'd3; a_data = 32'h5500_0000 + 32'(i * 7);
            drive_cycle();
            e = sbq.pop_front();
            total++;
            if (obs_ar !== 1'b1 || {rf_wr, rf_sel, rf_data} !== e)
                $display("FAIL b2b[%0d]: got rdy=%b %b/%0d/%h required 1 %b/%0d/%h",
                         i, obs_ar, rf_wr, rf_sel, rf_data, e.wr, e.sel, e.data);
            else passed++;
        end
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h0B0B0B0B;
        drive_cycle();
        e = sbq.pop_front();
        total++;
        if ({rf_wr, rf_sel, rf_data} !== {1'b1, 5'd3, 32'h0B0B0B0B})
            $display("FAIL same_reg_b: got %b/%0d/%h required 1/3/0b0b0b0b",
                     rf_wr, rf_sel, rf_data);
        else passed++;
        b_valid = 1'b0;
        drive_cycle();
        void'(sbq.pop_front());
    endtask

    task automatic test_reset_mid();
        sb_t e;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77777777;
        drive_cycle();
        e = sbq.pop_front();
        total++;
        if ({rf_wr, rf_sel, rf_data} !== e || rf_wr !== 1'b1)
            $display("FAIL mid_accept: got %b/%0d/%h required %b/%0d/%h",
                     rf_wr, rf_sel, rf_data, e.wr, e.sel, e.data);
        else passed++;
        #1;
        rst = 1'b0;
        #1;
        total++;
        if ({rf_wr, rf_sel, rf_data, a_ready} !== 39'd0)
            $display("FAIL mid_reset: got wr=%b sel=%0d data=%h rdy=%b required 0",
                     rf_wr, rf_sel, rf_data, a_ready);
        else passed++;
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        drive_cycle();
        e = sbq.pop_front();
        total++;
        if ({rf_wr, rf_sel, rf_data} !== e)
            $display("FAIL mid_after: got %b/%0d/%h required %b/%0d/%h",
                     rf_wr, rf_sel, rf_data, e.wr, e.sel, e.data);
        else passed++;
    endtask

    task automatic test_forward();
        sb_t e;
        logic        eh;
        logic [31:0] ed;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hCAFE0001;
        drive_cycle();
        a_valid = 1'b0;
        e = sbq.pop_front();
        total++;
        if ({rf_wr, rf_sel, rf_data} !== e)
            $display("FAIL fwd_out: got %b/%0d/%h required %b/%0d/%h",
                     rf_wr, rf_sel, rf_data, e.wr, e.sel, e.data);
        else passed++;
`ifdef RF_ARB_FWD_EN
        eh = 1'b1; ed = 32'hCAFE0001;
`else
        eh = 1'b0; ed = 32'd0;
`endif
        chk_addr = 5'd9;
        #1;
        total++;
        if ({chk_hit, chk_data} !== {eh, ed})
            $display("FAIL fwd_hit: got %b/%h required %b/%h", chk_hit, chk_data, eh, ed);
        else passed++;
        chk_addr = 5'd4;
        #1;
        total++;
        if ({chk_hit, chk_data} !== 33'd0)
            $display("FAIL fwd_miss: got %b/%h required 0/0", chk_hit, chk_data);
        else passed++;
        chk_addr = 5'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_a();
        test_starvation();
        test_zero_drop();
        test_back_to_back();
        test_reset_mid();
        test_forward();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
